// File: rtl/system_worker_1_cpu_cpu_mult_combine.sv
`default_nettype none
// ============================================================================
// Module   : system_worker_1_cpu_cpu_mult_combine
// Purpose  : Combines registered 16x16 partial products into the MUL low word
//            or, with SYSTEM_WORKER_1_CPU_MULX_EN, the MULXUU/SU/SS high word.
// Revision : 1.0 - initial release
// ============================================================================
module system_worker_1_cpu_cpu_mult_combine (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    input  logic [31:0] in_p1,
    input  logic [31:0] in_p2,
    input  logic [31:0] in_p3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
);

`ifdef SYSTEM_WORKER_1_CPU_MULX_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SUM  = 3'd1,
        S_HIHI = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] c_OP_MUL    = 2'd0;
    localparam logic [1:0] c_OP_MULXSU = 2'd2;
    localparam logic [1:0] c_OP_MULXSS = 2'd3;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SUM  = 3'd1,
        S_DONE = 3'd4
    } state_t;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_p1;
    logic [31:0] r_p2;
    logic [31:0] r_p3;
    logic [31:0] r_result;
    logic [32:0] w_mid;
    logic [32:0] w_low_sum;

    assign w_mid     = {1'b0, r_p2} + {1'b0, r_p3};
    assign w_low_sum = {1'b0, r_p1} + {1'b0, w_mid[15:0], 16'h0000};

`ifdef SYSTEM_WORKER_1_CPU_MULX_EN
    logic [1:0]  r_op;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [3:0]  r_cnt;
    logic [31:0] r_acc_hi;
    logic [31:0] r_hh;
    logic        w_is_mul;
    logic [15:0] w_src2_hi;
    logic [31:0] w_hh_term;
    logic [31:0] w_corr;
    logic [31:0] w_hi;

    assign w_is_mul  = (r_op == c_OP_MUL);
    assign w_src2_hi = r_src2[31:16];
    assign w_hh_term = {16'h0000, r_src1[31:16]} << r_cnt;

    // Converts the unsigned high word into the signed variants.
    always_comb begin
        w_corr = 32'd0;
        if (r_op == c_OP_MULXSS) begin
            w_corr = (r_src1[31] ? r_src2 : 32'd0) + (r_src2[31] ? r_src1 : 32'd0);
        end else if (r_op == c_OP_MULXSU) begin
            w_corr = r_src1[31] ? r_src2 : 32'd0;
        end
    end

    assign w_hi = r_acc_hi + r_hh - w_corr;
`else
    logic w_unused_ok;
    assign w_unused_ok = ^{in_op, in_src1, in_src2, w_mid[32:16], w_low_sum[32]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_SUM;
                end
            end
`ifdef SYSTEM_WORKER_1_CPU_MULX_EN
            S_SUM:  w_state_next = w_is_mul ? S_DONE : S_HIHI;
            S_HIHI: begin
                if (r_cnt == 4'd15) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX:  w_state_next = S_DONE;
`else
            S_SUM:  w_state_next = S_DONE;
`endif
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1     <= 32'd0;
            r_p2     <= 32'd0;
            r_p3     <= 32'd0;
            r_result <= 32'd0;
`ifdef SYSTEM_WORKER_1_CPU_MULX_EN
            r_op     <= 2'd0;
            r_src1   <= 32'd0;
            r_src2   <= 32'd0;
            r_cnt    <= 4'd0;
            r_acc_hi <= 32'd0;
            r_hh     <= 32'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_p1   <= in_p1;
                        r_p2   <= in_p2;
                        r_p3   <= in_p3;
`ifdef SYSTEM_WORKER_1_CPU_MULX_EN
                        r_op   <= in_op;
                        r_src1 <= in_src1;
                        r_src2 <= in_src2;
`endif
                    end
                end
                S_SUM: begin
`ifdef SYSTEM_WORKER_1_CPU_MULX_EN
                    if (w_is_mul) begin
                        r_result <= w_low_sum[31:0];
                    end else begin
                        // Upper half of the middle terms plus the carry out of the low word.
                        r_acc_hi <= {15'd0, w_mid[32:16]} + {31'd0, w_low_sum[32]};
                        r_hh     <= 32'd0;
                        r_cnt    <= 4'd0;
                    end
`else
                    r_result <= w_low_sum[31:0];
`endif
                end
`ifdef SYSTEM_WORKER_1_CPU_MULX_EN
                S_HIHI: begin
                    if (w_src2_hi[r_cnt]) begin
                        r_hh <= r_hh + w_hh_term;
                    end
                    r_cnt <= r_cnt + 4'd1;
                end
                S_FIX: begin
                    r_result <= w_hi;
                end
`endif
                default: ;
            endcase
        end
    end

    assign out_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_system_worker_1_cpu_cpu_mult_combine.sv
`default_nettype none
// Testbench for system_worker_1_cpu_cpu_mult_combine: directed table, hand
// sequences for backpressure/reset/throughput, and randomized model checks.
module tb_system_worker_1_cpu_cpu_mult_combine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1, in_src2, in_p1, in_p2, in_p3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    system_worker_1_cpu_cpu_mult_combine dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_p1      (in_p1),
        .in_p2      (in_p2),
        .in_p3      (in_p3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] s1, s2, p1, p2, p3;
        logic [31:0] exp_mulx;
        logic [31:0] exp_mul;
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: full-width product of the (sign-)extended operands.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, prod;
`ifdef SYSTEM_WORKER_1_CPU_MULX_EN
        xa = (op >= 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (op == 2'd3) ? {{32{b[31]}}, b} : {32'd0, b};
        prod = xa * xb;
        return (op == 2'd0) ? prod[31:0] : prod[63:32];
`else
        xa = {32'd0, a};
        xb = {32'd0, b};
        prod = xa * xb;
        return prod[31:0];
`endif
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
`ifdef SYSTEM_WORKER_1_CPU_MULX_EN
        return (op == 2'd0) ? 1 : 18;
`else
        return 1;
`endif
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                          input logic [31:0] exp, input string name, input int hold);
        int lat;
        @(negedge clk);
        chk({name, "_ready_before"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_op = op; in_src1 = s1; in_src2 = s2;
        in_p1 = p1; in_p2 = p2; in_p3 = p3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op = 2'($urandom); in_src1 = $urandom; in_src2 = $urandom;
        in_p1 = $urandom; in_p2 = $urandom; in_p3 = $urandom;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 60);
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat(op)));
        chk({name, "_result"}, out_result, exp);
        chk({name, "_busy"}, {31'd0, in_ready}, 32'd0);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        if (hold > 0) begin
            chk({name, "_held_valid"}, {31'd0, out_valid}, 32'd1);
            chk({name, "_held_result"}, out_result, exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_taken_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_taken_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b, held;
        int          accepts;
        int          acc_exp;

        vecs[0] = '{2'd0, 32'h00010002, 32'h00030004, 32'd8, 32'd6, 32'd4, 32'h000A0008, 32'h000A0008, "mul_basic"};
        vecs[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFFFFFE, 32'h00000001, "mulxuu_ones"};
        vecs[2] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'h00000000, 32'h00000001, "mulxss_ones"};
        vecs[3] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFFFFFF, 32'h00000001, "mulxsu_ones"};
        vecs[4] = '{2'd1, 32'h00010002, 32'h00030004, 32'd8, 32'd6, 32'd4, 32'h00000003, 32'h000A0008, "mulxuu_small"};
        vecs[5] = '{2'd3, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'd0, 32'h40000000, 32'h00000000, "mulxss_minneg"};
        vecs[6] = '{2'd2, 32'hFFFFFFFE, 32'h00000002, 32'h0001FFFC, 32'd0, 32'h0001FFFE, 32'hFFFFFFFF, 32'hFFFFFFFC, "mulxsu_neg2"};

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 2'd0; in_src1 = '0; in_src2 = '0; in_p1 = '0; in_p2 = '0; in_p3 = '0;
        #12;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_result", out_result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
`ifdef SYSTEM_WORKER_1_CPU_MULX_EN
            run_op(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].p1, vecs[i].p2, vecs[i].p3,
                   vecs[i].exp_mulx, vecs[i].name, 0);
`else
            run_op(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].p1, vecs[i].p2, vecs[i].p3,
                   vecs[i].exp_mul, vecs[i].name, 0);
`endif
        end

        // Backpressure: result held for 5 cycles while in_valid pulses are ignored.
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'd0;
        in_src1 = 32'h00010002; in_src2 = 32'h00030004; in_p1 = 32'd8; in_p2 = 32'd6; in_p3 = 32'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        held = out_result;
        chk("bp_result", held, 32'h000A0008);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_p1 = $urandom; in_p2 = $urandom; in_p3 = $urandom;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_result", out_result, 32'h000A0008);
            chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bp_taken_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_taken_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_second_accept", {31'd0, out_valid}, 32'd0);
        chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'd1;
        in_src1 = 32'hFFFFFFFF; in_src2 = 32'hFFFFFFFF;
        in_p1 = 32'hFFFE0001; in_p2 = 32'hFFFE0001; in_p3 = 32'hFFFE0001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_result", out_result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(2'd1, 32'h00020000, 32'h00030000, 32'd0, 32'd0, 32'd0,
               model(2'd1, 32'h00020000, 32'h00030000), "after_reset", 0);

        // Throughput with out_ready tied high and in_valid held.
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_op = 2'd0;
        in_src1 = 32'd3; in_src2 = 32'd5; in_p1 = 32'd15; in_p2 = 32'd0; in_p3 = 32'd0;
        accepts = 0;
        for (int i = 0; i < 30; i++) begin
            if (in_ready) accepts++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("tput_mul", 32'(accepts), 32'd10);
`ifdef SYSTEM_WORKER_1_CPU_MULX_EN
        acc_exp = 2;
`else
        acc_exp = 10;
`endif
        in_valid = 1'b1; in_op = 2'd1;
        accepts = 0;
        for (int i = 0; i < ((acc_exp == 2) ? 40 : 30); i++) begin
            if (in_ready) accepts++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("tput_mulx", 32'(accepts), 32'(acc_exp));
        for (int i = 0; i < 40 && !(in_ready && !out_valid); i++) @(negedge clk);
        out_ready = 1'b0;
        chk("tput_drain", {31'd0, in_ready}, 32'd1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: a = 32'h80000000;
                1: a = 32'hFFFFFFFF;
                2: a = 32'h7FFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'h80000000;
                1: b = 32'hFFFFFFFF;
                2: b = 32'h0000FFFF;
                default: b = $urandom;
            endcase
            run_op(op, a, b,
                   {16'd0, a[15:0]} * {16'd0, b[15:0]},
                   {16'd0, a[15:0]} * {16'd0, b[31:16]},
                   {16'd0, a[31:16]} * {16'd0, b[15:0]},
                   model(op, a, b), "rand", $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
